// File: rtl/room_sequencer.sv
// Game-flow controller: owns the room index, sequences room changes, death/respawn and game over.
// Reset pulses are combinational from the one-cycle LOAD state; everything else advances on frame ticks.
module room_sequencer #(
    parameter logic [9:0] EDGE_X       = 10'd600,
    parameter logic [1:0] NUM_ROOMS    = 2'd3,
    parameter logic [7:0] DEATH_FRAMES = 8'd90,
    parameter logic [2:0] LIVES        = 3'd3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] mario_x,
    input  logic [1:0] is_alive_mario,
    input  logic       start,
    output logic [1:0] roomNum,
    output logic       enemy_reset,
    output logic       mario_reset,
    output logic       freeze,
    output logic [3:0] fade_level,
    output logic [2:0] lives,
    output logic       game_over
);

    typedef enum logic [2:0] {
        PLAY       = 3'd0,
        FADE_OUT   = 3'd1,
        LOAD       = 3'd2,
        FADE_IN    = 3'd3,
        DEATH_WAIT = 3'd4,
        GAME_OVER  = 3'd5
    } state_t;

    state_t     state_q, state_n;
    logic [1:0] room_q, room_n;
    logic [2:0] lives_q, lives_n;
    logic [3:0] fade_q, fade_n;
    logic [7:0] cnt_q, cnt_n;
    logic       respawn_q, respawn_n;
    logic       frame_clk_d;
    logic       tick;

    assign tick = frame_clk & ~frame_clk_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= PLAY;
            room_q      <= 2'd1;
            lives_q     <= LIVES;
            fade_q      <= 4'd0;
            cnt_q       <= 8'd0;
            respawn_q   <= 1'b0;
            frame_clk_d <= 1'b0;
        end else begin
            state_q     <= state_n;
            room_q      <= room_n;
            lives_q     <= lives_n;
            fade_q      <= fade_n;
            cnt_q       <= cnt_n;
            respawn_q   <= respawn_n;
            frame_clk_d <= frame_clk;
        end
    end

    always_comb begin
        state_n     = state_q;
        room_n      = room_q;
        lives_n     = lives_q;
        fade_n      = fade_q;
        cnt_n       = cnt_q;
        respawn_n   = respawn_q;
        freeze      = 1'b1;
        enemy_reset = 1'b0;
        mario_reset = 1'b0;
        game_over   = 1'b0;

        case (state_q)
            PLAY: begin
                freeze = 1'b0;
                if (tick) begin
                    if (is_alive_mario == 2'd0) begin
                        state_n = DEATH_WAIT;
                        cnt_n   = 8'd0;
                    end else if (mario_x >= EDGE_X) begin
                        state_n   = FADE_OUT;
                        respawn_n = 1'b0;
                    end
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (fade_q >= 4'd14) begin
                        fade_n  = 4'd15;
                        state_n = LOAD;
                    end else begin
                        fade_n = fade_q + 4'd1;
                    end
                end
            end
            LOAD: begin
                enemy_reset = 1'b1;
                mario_reset = 1'b1;
                if (!respawn_q) begin
                    room_n = (room_q >= NUM_ROOMS) ? 2'd1 : room_q + 2'd1;
                end
                respawn_n = 1'b0;
                state_n   = FADE_IN;
            end
            FADE_IN: begin
                if (tick) begin
                    if (fade_q <= 4'd1) begin
                        fade_n  = 4'd0;
                        state_n = PLAY;
                    end else begin
                        fade_n = fade_q - 4'd1;
                    end
                end
            end
            DEATH_WAIT: begin
                if (tick) begin
                    cnt_n = cnt_q + 8'd1;
                    if (cnt_n == DEATH_FRAMES) begin
                        // A stray zero-lives entry still lands in GAME_OVER rather than wrapping.
                        if (lives_q <= 3'd1) begin
                            lives_n = 3'd0;
                            fade_n  = 4'd15;
                            state_n = GAME_OVER;
                        end else begin
                            lives_n   = lives_q - 3'd1;
                            respawn_n = 1'b1;
                            state_n   = FADE_OUT;
                        end
                    end
                end
            end
            GAME_OVER: begin
                game_over = 1'b1;
                fade_n    = 4'd15;
                if (start) begin
                    lives_n   = LIVES;
                    room_n    = 2'd1;
                    respawn_n = 1'b1;
                    state_n   = LOAD;
                end
            end
            default: begin
                state_n = PLAY;
            end
        endcase
    end

    assign roomNum    = room_q;
    assign lives      = lives_q;
    assign fade_level = fade_q;

endmodule

// File: tb/tb_room_sequencer.sv
// Directed bench for room_sequencer: room advance, wrap, death, game over/restart, mid-transition reset.
module tb_room_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] mario_x = 10'd100;
    logic [1:0] is_alive_mario = 2'd1;
    logic       start = 1'b0;
    logic [1:0] roomNum;
    logic       enemy_reset;
    logic       mario_reset;
    logic       freeze;
    logic [3:0] fade_level;
    logic [2:0] lives;
    logic       game_over;

    int vectors = 0;
    int miscompares = 0;
    int er_cnt = 0;
    int mr_cnt = 0;
    int consec = 0;
    logic er_prev = 1'b0;
    logic mr_prev = 1'b0;

    room_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .mario_x        (mario_x),
        .is_alive_mario (is_alive_mario),
        .start          (start),
        .roomNum        (roomNum),
        .enemy_reset    (enemy_reset),
        .mario_reset    (mario_reset),
        .freeze         (freeze),
        .fade_level     (fade_level),
        .lives          (lives),
        .game_over      (game_over)
    );

    always #5 Clk = ~Clk;

    // Pulse monitor samples mid-cycle; the stimulus acts 1 ns later so counts are settled.
    always @(negedge Clk) begin
        if (enemy_reset) er_cnt++;
        if (mario_reset) mr_cnt++;
        if ((enemy_reset && er_prev) || (mario_reset && mr_prev)) consec++;
        er_prev = enemy_reset;
        mr_prev = mario_reset;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge Clk);
        #1;
    endtask

    task automatic do_tick();
        nclk();
        frame_clk = 1'b1;
        nclk();
        frame_clk = 1'b0;
        nclk();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Full fade-out / LOAD / fade-in after the entry tick; expects room afterwards.
    task automatic run_transition(input string tag, input int exp_room);
        int er0, mr0;
        er0 = er_cnt;
        mr0 = mr_cnt;
        ticks(14);
        check_val({tag, "_fade14"}, fade_level, 14);
        check_val({tag, "_nopulse_early"}, er_cnt - er0, 0);
        do_tick();
        check_val({tag, "_enemy_pulse"}, er_cnt - er0, 1);
        check_val({tag, "_mario_pulse"}, mr_cnt - mr0, 1);
        check_val({tag, "_room"}, roomNum, exp_room);
        check_val({tag, "_fade15"}, fade_level, 15);
        ticks(14);
        check_val({tag, "_fadein1"}, fade_level, 1);
        check_val({tag, "_frz_in"}, freeze, 1);
        do_tick();
        check_val({tag, "_fade0"}, fade_level, 0);
        check_val({tag, "_unfrz"}, freeze, 0);
    endtask

    task automatic advance(input string tag, input int exp_room);
        mario_x = 10'd600;
        is_alive_mario = 2'd1;
        do_tick();
        check_val({tag, "_enter_frz"}, freeze, 1);
        mario_x = 10'd100;
        run_transition(tag, exp_room);
    endtask

    // Death with respawn: 90 ticks in DEATH_WAIT, then a same-room transition.
    task automatic die(input string tag, input int exp_lives_before);
        mario_x = 10'd600;
        is_alive_mario = 2'd0;
        do_tick();
        is_alive_mario = 2'd1;
        mario_x = 10'd100;
        ticks(5);
        check_val({tag, "_wait_fade"}, fade_level, 0);
        check_val({tag, "_wait_frz"}, freeze, 1);
        ticks(84);
        check_val({tag, "_lives89"}, lives, exp_lives_before);
        do_tick();
        check_val({tag, "_lives90"}, lives, exp_lives_before - 1);
    endtask

    initial begin
        int room_before, er0;
        nclk();
        nclk();
        Reset = 1'b0;
        nclk();
        check_val("rst_room", roomNum, 1);
        check_val("rst_lives", lives, 3);
        check_val("rst_fade", fade_level, 0);
        check_val("rst_freeze", freeze, 0);
        check_val("rst_er", enemy_reset, 0);
        check_val("rst_mr", mario_reset, 0);
        check_val("rst_go", game_over, 0);

        // Idle play with start held: nothing may change.
        start = 1'b1;
        ticks(4);
        start = 1'b0;
        check_val("idle_room", roomNum, 1);
        check_val("idle_freeze", freeze, 0);
        check_val("idle_lives", lives, 3);
        check_val("idle_pulses", er_cnt, 0);

        advance("adv1", 2);
        advance("adv2", 3);
        mario_x = 10'd610;
        do_tick();
        mario_x = 10'd100;
        run_transition("wrap", 1);
        check_val("wrap_lives", lives, 3);

        advance("pre_d1", 2);
        die("death1", 3);
        run_transition("resp1", 2);
        die("death2", 2);
        run_transition("resp2", 2);
        advance("pre_d3", 3);

        er0 = er_cnt;
        die("death3", 1);
        check_val("go_lives", lives, 0);
        check_val("go_flag", game_over, 1);
        check_val("go_fade", fade_level, 15);
        check_val("go_freeze", freeze, 1);
        ticks(3);
        check_val("go_hold", game_over, 1);
        check_val("go_nopulse", er_cnt - er0, 0);

        nclk();
        start = 1'b1;
        nclk();
        start = 1'b0;
        nclk();
        check_val("restart_pulse", er_cnt - er0, 1);
        check_val("restart_room", roomNum, 1);
        check_val("restart_lives", lives, 3);
        check_val("restart_go", game_over, 0);
        check_val("restart_fade", fade_level, 15);
        ticks(15);
        check_val("restart_play_fade", fade_level, 0);
        check_val("restart_play_frz", freeze, 0);

        // Reset in the middle of a fade-out.
        advance("pre_rst", 2);
        room_before = roomNum;
        check_val("pre_rst_room", room_before, 2);
        mario_x = 10'd600;
        do_tick();
        mario_x = 10'd100;
        ticks(7);
        check_val("mid_fade7", fade_level, 7);
        er0 = er_cnt;
        Reset = 1'b1;
        nclk();
        check_val("mid_rst_room", roomNum, 1);
        check_val("mid_rst_fade", fade_level, 0);
        check_val("mid_rst_freeze", freeze, 0);
        check_val("mid_rst_lives", lives, 3);
        check_val("mid_rst_er", enemy_reset, 0);
        check_val("mid_rst_mr", mario_reset, 0);
        Reset = 1'b0;
        ticks(3);
        check_val("mid_rst_nopulse", er_cnt - er0, 0);
        check_val("post_rst_fade", fade_level, 0);
        check_val("consecutive_pulses", consec, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
